// File: rtl/trace_readout_ctrl_if.sv
// Trace RAM read port shared between the readout controller (master)
// and the trace buffer RAM (slave).
interface trace_readout_ctrl_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [31:0]           mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data
    );
endinterface

// File: rtl/trace_readout_ctrl.sv
// Trace readout controller: once a capture completes, walks the circular
// trace buffer from the oldest packet and hands two 32-bit packets per HUB
// read command to the eight upload byte registers.
module trace_readout_ctrl #(
    parameter int ADDR_WIDTH          = 10,
    parameter int SAMPLE_PACKET_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_done,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [31:0]           sample_count,
    input  logic                  start_readout,
    input  logic                  read_req,
    input  logic                  abort,
    trace_readout_ctrl_if.master  ram,
    output logic [7:0]            regOut0,
    output logic [7:0]            regOut1,
    output logic [7:0]            regOut2,
    output logic [7:0]            regOut3,
    output logic [7:0]            regOut4,
    output logic [7:0]            regOut5,
    output logic [7:0]            regOut6,
    output logic [7:0]            regOut7,
    output logic [7:0]            status
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] TWO       = (ADDR_WIDTH+1)'(2);

    // The byte packing below only makes sense for 32-bit packets.
    if (SAMPLE_PACKET_WIDTH != 32) begin : g_bad_packet_width
        $error("trace_readout_ctrl: SAMPLE_PACKET_WIDTH must be 32");
    end

    typedef enum logic [2:0] {
        IDLE,
        READY,
        RD0,
        RD1,
        CAP1,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  busy;
    logic                  block_valid;
    logic                  done;
    logic                  last_block;

    logic [ADDR_WIDTH:0]   clamped_count;
    logic                  has_pair;
    logic [ADDR_WIDTH:0]   step;
    logic [ADDR_WIDTH:0]   remaining_next;

    // Clamp the requested count to the buffer depth and work out how many
    // packets the current block consumes.
    always_comb begin
        clamped_count = sample_count[ADDR_WIDTH:0];
        if (sample_count > 32'(DEPTH)) begin
            clamped_count = DEPTH_CNT;
        end
        has_pair       = |remaining[ADDR_WIDTH:1];
        step           = has_pair ? TWO : remaining;
        remaining_next = remaining - step;
    end

    // Readout sequencer: arming, two-packet fetch, byte capture and abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            remaining       <= '0;
            ram.mem_rd_en   <= 1'b0;
            ram.mem_rd_addr <= '0;
            busy            <= 1'b0;
            block_valid     <= 1'b0;
            done            <= 1'b0;
            last_block      <= 1'b0;
            {regOut7, regOut6, regOut5, regOut4} <= 32'h0;
            {regOut3, regOut2, regOut1, regOut0} <= 32'h0;
        end else if (abort) begin
            state         <= IDLE;
            ram.mem_rd_en <= 1'b0;
            busy          <= 1'b0;
            block_valid   <= 1'b0;
            done          <= 1'b0;
            last_block    <= 1'b0;
        end else begin
            case (state)
                IDLE, READY, DONE: begin
                    if (start_readout && capture_done) begin
                        ptr           <= first_addr;
                        remaining     <= clamped_count;
                        ram.mem_rd_en <= 1'b0;
                        busy          <= 1'b0;
                        block_valid   <= 1'b0;
                        last_block    <= 1'b0;
                        done          <= (clamped_count == '0);
                        state         <= (clamped_count == '0) ? DONE : READY;
                    end else if (state == READY && read_req) begin
                        ram.mem_rd_en   <= 1'b1;
                        ram.mem_rd_addr <= ptr;
                        block_valid     <= 1'b0;
                        last_block      <= 1'b0;
                        busy            <= 1'b1;
                        state           <= RD0;
                    end
                end
                RD0: begin
                    ram.mem_rd_en <= has_pair;
                    if (has_pair) begin
                        ram.mem_rd_addr <= ptr + ADDR_WIDTH'(1);
                    end
                    state <= RD1;
                end
                RD1: begin
                    {regOut3, regOut2, regOut1, regOut0} <= ram.mem_rd_data;
                    ram.mem_rd_en <= 1'b0;
                    state         <= CAP1;
                end
                CAP1: begin
                    {regOut7, regOut6, regOut5, regOut4} <= has_pair ? ram.mem_rd_data : 32'h0;
                    ptr         <= ptr + step[ADDR_WIDTH-1:0];
                    remaining   <= remaining_next;
                    block_valid <= 1'b1;
                    busy        <= 1'b0;
                    last_block  <= (remaining_next == '0);
                    done        <= (remaining_next == '0);
                    state       <= (remaining_next == '0) ? DONE : READY;
                end
                default: begin
                    ram.mem_rd_en <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign status = {4'b0000, last_block, done, block_valid, busy};

endmodule

// File: tb/tb_trace_readout_ctrl.sv
// Directed testbench for trace_readout_ctrl with a 16-entry trace RAM model.
module tb_trace_readout_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_done;
    logic [AW-1:0] first_addr;
    logic [31:0]   sample_count;
    logic          start_readout;
    logic          read_req;
    logic          abort;
    logic [7:0]    regOut0, regOut1, regOut2, regOut3;
    logic [7:0]    regOut4, regOut5, regOut6, regOut7;
    logic [7:0]    status;

    logic [31:0]   mem [16];
    int            addr_log[$];
    int            check_count = 0;
    int            error_count = 0;
    int            base;

    trace_readout_ctrl_if #(.ADDR_WIDTH(AW)) ram_if ();

    trace_readout_ctrl #(
        .ADDR_WIDTH(AW),
        .SAMPLE_PACKET_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .capture_done(capture_done),
        .first_addr(first_addr),
        .sample_count(sample_count),
        .start_readout(start_readout),
        .read_req(read_req),
        .abort(abort),
        .ram(ram_if.master),
        .regOut0(regOut0),
        .regOut1(regOut1),
        .regOut2(regOut2),
        .regOut3(regOut3),
        .regOut4(regOut4),
        .regOut5(regOut5),
        .regOut6(regOut6),
        .regOut7(regOut7),
        .status(status)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous-read RAM model that also logs every read address.
    always @(posedge clk) begin
        if (ram_if.mem_rd_en) begin
            ram_if.mem_rd_data <= mem[ram_if.mem_rd_addr];
            addr_log.push_back(int'(ram_if.mem_rd_addr));
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] regs();
        return {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One-cycle pulse on the selected control inputs, starting at a negedge.
    task automatic applyStimulus(input logic sr, input logic rr, input logic ab);
        start_readout = sr;
        read_req      = rr;
        abort         = ab;
        @(negedge clk);
        start_readout = 1'b0;
        read_req      = 1'b0;
        abort         = 1'b0;
    endtask

    task automatic armReadout(input logic [AW-1:0] fa, input logic [31:0] cnt);
        first_addr   = fa;
        sample_count = cnt;
        capture_done = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    // Issue read_req and stop at the first sample where block_valid is due.
    task automatic readBlock();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        capture_done  = 1'b0;
        first_addr    = '0;
        sample_count  = '0;
        start_readout = 1'b0;
        read_req      = 1'b0;
        abort         = 1'b0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;
        for (int i = 4; i < 16; i++) begin
            mem[i] = 32'hC0DE0000 + 32'(i);
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_status", 64'(status), 64'h0);
        checkOutput("rst_regs", regs(), 64'h0);
        checkOutput("rst_en", 64'(ram_if.mem_rd_en), 64'h0);
        checkOutput("rst_addr", 64'(ram_if.mem_rd_addr), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // start_readout without capture_done is ignored
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("nocap_status", 64'(status), 64'h0);
        base = addr_log.size();
        readBlock();
        checkOutput("nocap_reads", 64'(addr_log.size() - base), 64'h0);

        // four-packet readout
        armReadout(4'd0, 32'd4);
        checkOutput("arm4_status", 64'(status), 64'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("b1_en0", 64'(ram_if.mem_rd_en), 64'h1);
        checkOutput("b1_addr0", 64'(ram_if.mem_rd_addr), 64'h0);
        checkOutput("b1_busy", 64'(status), 64'h01);
        @(negedge clk);
        checkOutput("b1_en1", 64'(ram_if.mem_rd_en), 64'h1);
        checkOutput("b1_addr1", 64'(ram_if.mem_rd_addr), 64'h1);
        @(negedge clk);
        checkOutput("b1_latency", 64'(status), 64'h01);
        @(negedge clk);
        checkOutput("b1_status", 64'(status), 64'h02);
        checkOutput("b1_regs", regs(), 64'h22222222_11111111);
        readBlock();
        checkOutput("b2_regs", regs(), 64'h44444444_33333333);
        checkOutput("b2_status", 64'(status), 64'h0E);
        base = addr_log.size();
        readBlock();
        checkOutput("done_drop_reads", 64'(addr_log.size() - base), 64'h0);
        checkOutput("done_hold_status", 64'(status), 64'h0E);
        checkOutput("done_hold_regs", regs(), 64'h44444444_33333333);

        // wrap from the last address to 0
        armReadout(4'd15, 32'd2);
        base = addr_log.size();
        readBlock();
        checkOutput("wrap_reads", 64'(addr_log.size() - base), 64'h2);
        checkOutput("wrap_addr0", 64'(addr_log[base]), 64'd15);
        checkOutput("wrap_addr1", 64'(addr_log[base+1]), 64'd0);
        checkOutput("wrap_regs", regs(), 64'h11111111_C0DE000F);
        checkOutput("wrap_status", 64'(status), 64'h0E);
        checkOutput("wrap_ptr", 64'(dut.ptr), 64'h1);

        // odd count
        armReadout(4'd4, 32'd3);
        readBlock();
        checkOutput("odd_b1_regs", regs(), 64'hC0DE0005_C0DE0004);
        checkOutput("odd_b1_status", 64'(status), 64'h02);
        base = addr_log.size();
        readBlock();
        checkOutput("odd_b2_reads", 64'(addr_log.size() - base), 64'h1);
        checkOutput("odd_b2_addr", 64'(addr_log[base]), 64'd6);
        checkOutput("odd_b2_regs", regs(), 64'h00000000_C0DE0006);
        checkOutput("odd_b2_status", 64'(status), 64'h0E);
        base = addr_log.size();
        readBlock();
        checkOutput("odd_b3_reads", 64'(addr_log.size() - base), 64'h0);

        // zero count goes straight to DONE
        armReadout(4'd0, 32'd0);
        checkOutput("zero_status", 64'(status), 64'h04);

        // count larger than the buffer is clamped to DEPTH
        armReadout(4'd2, 32'd21);
        base = addr_log.size();
        for (int b = 0; b < 8; b++) begin
            readBlock();
            checkOutput($sformatf("clamp_status%0d", b), 64'(status), (b == 7) ? 64'h0E : 64'h02);
        end
        checkOutput("clamp_reads", 64'(addr_log.size() - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("clamp_addr%0d", i), 64'(addr_log[base+i]), 64'((2 + i) % 16));
        end
        checkOutput("clamp_last_regs", regs(), 64'h22222222_11111111);
        readBlock();
        checkOutput("clamp_extra_reads", 64'(addr_log.size() - base), 64'd16);

        // abort while the first packet is being captured
        armReadout(4'd8, 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_en", 64'(ram_if.mem_rd_en), 64'h0);
        checkOutput("abort_status", 64'(status), 64'h0);
        checkOutput("abort_regs", regs(), 64'h22222222_11111111);
        base = addr_log.size();
        readBlock();
        checkOutput("abort_idle_reads", 64'(addr_log.size() - base), 64'h0);
        checkOutput("abort_idle_status", 64'(status), 64'h0);

        // read_req during RD0 is dropped
        armReadout(4'd0, 32'd4);
        base = addr_log.size();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("drop_reads", 64'(addr_log.size() - base), 64'h2);
        checkOutput("drop_status", 64'(status), 64'h02);

        // reset in the middle of a fetch
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midrst_pre_en", 64'(ram_if.mem_rd_en), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_en", 64'(ram_if.mem_rd_en), 64'h0);
        checkOutput("midrst_addr", 64'(ram_if.mem_rd_addr), 64'h0);
        checkOutput("midrst_status", 64'(status), 64'h0);
        checkOutput("midrst_regs", regs(), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
